// File: rtl/qspi_seq_pkg.sv
// ---------------------------------------------------------------------------
// qspi_seq_pkg
//
// Shared definitions for the QSPI flash command sequencer:
//   - seq_state_t : sequencer FSM states
//   - seq_op_t    : host operation codes (READ / WRITE_RAW)
//   - QSPI core register addresses and control-word bit positions
//   - build_ctrl(): assembles the base control word for an operation
// ---------------------------------------------------------------------------
package qspi_seq_pkg;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_WR_CMD   = 4'd1,
    S_WR_DATA  = 4'd2,
    S_WR_CTRL  = 4'd3,
    S_WAIT     = 4'd4,
    S_CLR_INTR = 4'd5,
    S_REL_INTR = 4'd6,
    S_CLR_CORE = 4'd7,
    S_DIS_CORE = 4'd8,
    S_RESP     = 4'd9
  } seq_state_t;

  typedef enum logic {
    OP_READ      = 1'b0,
    OP_WRITE_RAW = 1'b1
  } seq_op_t;

  // QSPI core register map
  localparam logic [23:0] QSPI_CTRL_ADDR = 24'd0;
  localparam logic [23:0] QSPI_CMD_ADDR  = 24'd4;
  localparam logic [23:0] QSPI_DATA_ADDR = 24'd8;
  localparam logic [23:0] QSPI_ICLR_ADDR = 24'd12;
  localparam logic [23:0] QSPI_STAT_ADDR = 24'd16;

  // Control register bit positions
  localparam int unsigned CTRL_START_BIT = 23;
  localparam int unsigned CTRL_CLR_BIT   = 24;
  localparam int unsigned CTRL_ENB_BIT   = 15;
  localparam int unsigned CTRL_WONLY_BIT = 16;

  localparam logic [31:0] CTRL_START_MASK = 32'd1 << CTRL_START_BIT;
  localparam logic [31:0] CTRL_CLR_MASK   = 32'd1 << CTRL_CLR_BIT;

  // Largest payload the core can shift out in one transfer
  localparam logic [5:0] MAX_WBITS = 6'd32;

  // Base control word (no start/clear bit). READ always fetches one 32-bit
  // word after a 24-bit address phase; WRITE_RAW shifts out wbits bits and
  // sets write-only so the core skips its receive phase.
  function automatic logic [31:0] build_ctrl(input seq_op_t    op,
                                             input logic [5:0] wbits,
                                             input logic [4:0] dummy);
    logic [31:0] cw;
    cw               = '0;
    cw[CTRL_ENB_BIT] = 1'b1;
    if (op == OP_READ) begin
      cw[5:0]   = 6'd24;
      cw[11:6]  = 6'd32;
      cw[22:18] = dummy;
    end else begin
      cw[5:0]            = (wbits > MAX_WBITS) ? MAX_WBITS : wbits;
      cw[CTRL_WONLY_BIT] = 1'b1;
    end
    return cw;
  endfunction

endpackage

// File: rtl/qspi_flash_seq.sv
// ---------------------------------------------------------------------------
// qspi_flash_seq
//
// Single-transaction front end for the QSPI core's register port. One host
// request (READ or WRITE_RAW) is turned into the core's register sequence:
// command, data, control+start; then the sequencer waits for the core's
// done interrupt, captures read data, clears the interrupt and the core,
// and presents a response.
//
// Optional build macro:
//   QSPI_SEQ_TIMEOUT_EN - adds a TIMEOUT_W-bit wait counter; an expired wait
//                         still runs the clear sequence and reports rsp_err_o.
//                         Undefined: WAIT is unbounded and rsp_err_o is 0.
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   req_valid_i/req_ready_o  request handshake (ready only in IDLE)
//   req_op_i                 0 = READ, 1 = WRITE_RAW
//   req_addr_i               24-bit flash address (READ)
//   req_cmd_i                command byte (WRITE_RAW)
//   req_wdata_i, req_wbits_i payload and bit count 0..32 (WRITE_RAW)
//   rsp_valid_o/rsp_ready_i  response handshake
//   rsp_rdata_o, rsp_err_o   read data (0 for WRITE_RAW), timeout flag
//   we_o, re_o, be_o         core register write/read strobes, byte enables
//   addr_o, wdata_o          core register address and write data
//   rdata_i                  core register read data
//   intr_rx_i, intr_tx_i     core receive-done pulse, transmit-done level
// ---------------------------------------------------------------------------
module qspi_flash_seq
  import qspi_seq_pkg::*;
#(
  parameter logic [4:0]  DUMMY_CYCLES = 5'd8,
  parameter logic [7:0]  READ_CMD     = 8'h03,
  parameter int unsigned TIMEOUT_W    = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,

  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_op_i,
  input  logic [23:0] req_addr_i,
  input  logic [7:0]  req_cmd_i,
  input  logic [31:0] req_wdata_i,
  input  logic [5:0]  req_wbits_i,

  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,

  output logic        we_o,
  output logic        re_o,
  output logic [3:0]  be_o,
  output logic [23:0] addr_o,
  output logic [31:0] wdata_o,
  input  logic [31:0] rdata_i,
  input  logic        intr_rx_i,
  input  logic        intr_tx_i
);

  if (TIMEOUT_W < 2) begin : g_timeout_w_check
    $error("qspi_flash_seq: TIMEOUT_W must be at least 2");
  end

  seq_state_t  state_q, state_d;
  seq_op_t     op_q, op_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [31:0] data_q, data_d;
  logic [31:0] cw_q, cw_d;
  logic [31:0] rdata_q, rdata_d;

  logic accept;
  logic irq_done;
  logic tmo_hit;

  // Ready is gated with the reset so the host never sees it during reset.
  assign req_ready_o = (state_q == S_IDLE) && rst_ni;
  assign accept      = req_valid_i && req_ready_o;
  assign be_o        = 4'hF;

  // READ completes on the rx pulse, WRITE_RAW on the tx level.
  assign irq_done = (op_q == OP_READ) ? intr_rx_i : intr_tx_i;

`ifdef QSPI_SEQ_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic                 err_q, err_d;

  assign tmo_hit = (state_q == S_WAIT) && (tmo_cnt_q == {TIMEOUT_W{1'b1}});

  // The counter idles at zero outside WAIT, so it starts from zero on every
  // WAIT entry. The error flag survives until the next accepted request.
  always_comb begin
    tmo_cnt_d = '0;
    err_d     = err_q;
    if (state_q == S_WAIT) begin
      tmo_cnt_d = tmo_cnt_q + 1'b1;
    end
    if (accept) begin
      err_d = 1'b0;
    end else if (tmo_hit && !irq_done) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tmo_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      err_q     <= err_d;
    end
  end

  assign rsp_err_o   = err_q;
  // Captured data is masked rather than overwritten, so the register only
  // ever changes on a real READ capture.
  assign rsp_rdata_o = ((op_q == OP_READ) && !err_q) ? rdata_q : '0;
`else
  assign tmo_hit     = 1'b0;
  assign rsp_err_o   = 1'b0;
  assign rsp_rdata_o = (op_q == OP_READ) ? rdata_q : '0;
`endif

  // Next-state and register-port outputs. Every write state lasts one
  // cycle; only WAIT and RESP can stall.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    cmd_d       = cmd_q;
    data_d      = data_q;
    cw_d        = cw_q;
    rdata_d     = rdata_q;
    we_o        = 1'b0;
    re_o        = 1'b0;
    addr_o      = QSPI_CTRL_ADDR;
    wdata_o     = '0;
    rsp_valid_o = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d  = seq_op_t'(req_op_i);
          cmd_d = req_op_i ? req_cmd_i : READ_CMD;
          data_d = req_op_i ? req_wdata_i : {8'b0, req_addr_i};
          cw_d  = build_ctrl(seq_op_t'(req_op_i), req_wbits_i, DUMMY_CYCLES);
          state_d = S_WR_CMD;
        end
      end
      S_WR_CMD: begin
        we_o    = 1'b1;
        addr_o  = QSPI_CMD_ADDR;
        wdata_o = {24'b0, cmd_q};
        state_d = S_WR_DATA;
      end
      S_WR_DATA: begin
        we_o    = 1'b1;
        addr_o  = QSPI_DATA_ADDR;
        wdata_o = data_q;
        state_d = S_WR_CTRL;
      end
      S_WR_CTRL: begin
        we_o    = 1'b1;
        addr_o  = QSPI_CTRL_ADDR;
        wdata_o = cw_q | CTRL_START_MASK;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Any address other than status returns the rx word, so the read
        // strobe is parked on the data register for the capture.
        re_o   = 1'b1;
        addr_o = QSPI_DATA_ADDR;
        if (irq_done) begin
          if (op_q == OP_READ) begin
            rdata_d = rdata_i;
          end
          state_d = S_CLR_INTR;
        end else if (tmo_hit) begin
          state_d = S_CLR_INTR;
        end
      end
      S_CLR_INTR: begin
        we_o    = 1'b1;
        addr_o  = QSPI_ICLR_ADDR;
        wdata_o = 32'd1;
        state_d = S_REL_INTR;
      end
      S_REL_INTR: begin
        we_o    = 1'b1;
        addr_o  = QSPI_ICLR_ADDR;
        wdata_o = 32'd0;
        state_d = S_CLR_CORE;
      end
      S_CLR_CORE: begin
        // Clear bit forces the core back to idle and drops its stop latch.
        we_o    = 1'b1;
        addr_o  = QSPI_CTRL_ADDR;
        wdata_o = cw_q | CTRL_CLR_MASK;
        state_d = S_DIS_CORE;
      end
      S_DIS_CORE: begin
        we_o    = 1'b1;
        addr_o  = QSPI_CTRL_ADDR;
        wdata_o = 32'd0;
        state_d = S_RESP;
      end
      S_RESP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      op_q    <= OP_READ;
      cmd_q   <= '0;
      data_q  <= '0;
      cw_q    <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cmd_q   <= cmd_d;
      data_q  <= data_d;
      cw_q    <= cw_d;
      rdata_q <= rdata_d;
    end
  end

endmodule
